fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's synchronous FIFOs (syn_fifo / syn_fifo_dpram read port). It issues rd_en against the FIFO's empty flag and absorbs the FIFO's fixed read latency in a small skid buffer. It presents the data as a valid/ready stream with optional packet framing (m_last every pkt_len beats). It sits between a line/weight FIFO and the downstream compute or DMA consumer, and sustains 1 beat/cycle with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_stream_pkg.sv | 23 ++
 rtl/fifo_stream_reader_if.sv | 26 ++
 rtl/stream_skid_buf.sv | 71 +++++++
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared constants and helpers for
// FIFO-to-stream read adapters.
package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream with
// packet framing, master drives data.
interface fifo_stream_reader_if
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: small circular buffer with push/pop,
// registered head word and occupancy count.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [clog2(DEPTH+1)-1:0] occ
);
  localparam int PW = clog2(DEPTH);
  localparam int OW = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (occ != '0);
  assign do_pop = pop && valid;
  assign dout   = mem[rd_ptr];

  // storage and write pointer; cleared so the head reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= nxt(wr_ptr);
    end
  end

  // read pointer advances on every accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= nxt(rd_ptr);
    end
  end

  // occupancy holds when a push and a pop coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a
// valid/ready stream with optional packet framing.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  fifo_stream_reader_if.master  m,
  output logic                  idle
);
  localparam int SKID_DEPTH = RD_LATENCY + 2;
  localparam int OW = clog2(SKID_DEPTH + 1);

  if (!rd_lat_ok(RD_LATENCY)) begin : g_bad_lat
    $error("fifo_stream_reader: RD_LATENCY must be 1..3");
  end

  logic                  run_q;
  logic [RD_LATENCY-1:0] inflight;
  logic [OW-1:0]         occ;
  logic                  land;
  logic                  pop;
  int                    load;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic                  at_last;

  function automatic int ones(
    input logic [RD_LATENCY-1:0] v
  );
    int c;
    c = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // reads stay off until the first clock after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  // issue only when buffered + in-flight + new read fit
  always_comb begin
    load       = int'(occ) + ones(inflight);
    fifo_rd_en = run_q && enable && !fifo_empty &&
                 (load <= RD_LATENCY + 1);
  end

  // age issued reads until their data returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  assign land = inflight[RD_LATENCY-1];
  assign pop  = m.m_valid && m.m_ready;

  stream_skid_buf #(
    .DEPTH      (SKID_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (land),
    .din   (fifo_data),
    .pop   (pop),
    .dout  (m.m_data),
    .valid (m.m_valid),
    .occ   (occ)
  );

  assign last_idx = pkt_len - LEN_WIDTH'(1);
  assign at_last  = (pkt_len != '0) && (beat_cnt == last_idx);

  // beat position within the current packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= at_last ? '0 : beat_cnt + LEN_WIDTH'(1);
    end
  end

  assign m.m_last = m.m_valid && at_last;
  assign idle     = (occ == '0) && (inflight == '0) &&
                    !fifo_rd_en;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: two readers (latency 1 and 2)
// against a queue FIFO model and stream scoreboard.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct {
    int sel;
    int plen;
    int nw;
    int rm;
    int lasts;
    int run;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] pkt_len;
  logic          enable     [2];
  logic          fifo_empty [2];
  logic          rd_en      [2];
  logic [DW-1:0] fd         [2];
  logic          m_valid    [2];
  logic          m_ready    [2];
  logic [DW-1:0] m_data     [2];
  logic          m_last     [2];
  logic          idle       [2];

  logic [DW-1:0] fq    [2][$];
  logic [DW-1:0] exp_q [2][$];
  logic [DW-1:0] st0   [2];
  logic          rd_s    [2];
  logic          valid_s [2];
  logic          idle_s  [2];
  logic          rval    [2];
  int            rmode   [2];
  int            issued  [2];
  int            popped  [2];
  int            lasts   [2];
  int            rd_cur  [2];
  int            rd_run  [2];
  int            first_b [2];
  int            last_b  [2];
  int            cyc;
  int            checks;
  int            errors;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) s0 ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW)) s1 ();

  assign m_valid[0] = s0.m_valid;
  assign m_data[0]  = s0.m_data;
  assign m_last[0]  = s0.m_last;
  assign s0.m_ready = m_ready[0];
  assign m_valid[1] = s1.m_valid;
  assign m_data[1]  = s1.m_data;
  assign m_last[1]  = s1.m_last;
  assign s1.m_ready = m_ready[1];

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (1),
    .LEN_WIDTH  (LW)
  ) u0 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable[0]),
    .pkt_len    (pkt_len),
    .fifo_empty (fifo_empty[0]),
    .fifo_rd_en (rd_en[0]),
    .fifo_data  (fd[0]),
    .m          (s0.master),
    .idle       (idle[0])
  );

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (2),
    .LEN_WIDTH  (LW)
  ) u1 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable[1]),
    .pkt_len    (pkt_len),
    .fifo_empty (fifo_empty[1]),
    .fifo_rd_en (rd_en[1]),
    .fifo_data  (fd[1]),
    .m          (s1.master),
    .idle       (idle[1])
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fq[k].delete();
      exp_q[k].delete();
      st0[k]        = '0;
      fd[k]         = '0;
      fifo_empty[k] = 1'b1;
      rd_s[k]       = 1'b0;
      issued[k]     = 0;
      popped[k]     = 0;
      lasts[k]      = 0;
      rd_cur[k]     = 0;
      rd_run[k]     = 0;
      first_b[k]    = 0;
      last_b[k]     = 0;
    end
  endtask

  task automatic preload(int k, int n, int base);
    for (int i = 0; i < n; i++) begin
      fq[k].push_back(DW'(base + i));
      exp_q[k].push_back(DW'(base + i));
    end
    fifo_empty[k] = (fq[k].size() == 0);
  endtask

  task automatic sample(int k);
    int  outst;
    logic el;
    rd_s[k]    = rd_en[k];
    valid_s[k] = m_valid[k];
    idle_s[k]  = idle[k];
    if (rd_en[k]) begin
      chk("rd_from_empty",
          64'(fq[k].size() != 0), 64'(1));
      issued[k]++;
      rd_cur[k]++;
      if (rd_cur[k] > rd_run[k]) rd_run[k] = rd_cur[k];
    end else begin
      rd_cur[k] = 0;
    end
    outst = issued[k] - popped[k];
    chk("outstanding_bound",
        64'(outst <= k + 3), 64'(1));
    chk("idle", 64'(idle[k]), 64'(outst == 0));
    if (m_valid[k]) begin
      if (exp_q[k].size() == 0) begin
        chk("spurious_valid", 64'(1), 64'(0));
      end else begin
        el = (pkt_len != 0) &&
             ((popped[k] % int'(pkt_len)) ==
              int'(pkt_len) - 1);
        chk("m_data", 64'(m_data[k]),
            64'(exp_q[k][0]));
        chk("m_last", 64'(m_last[k]), 64'(el));
        if (m_ready[k]) begin
          void'(exp_q[k].pop_front());
          if (popped[k] == 0) first_b[k] = cyc;
          last_b[k] = cyc;
          popped[k]++;
          if (m_last[k]) lasts[k]++;
        end
      end
    end
  endtask

  task automatic fifo_step(int k);
    logic [DW-1:0] w;
    w = 32'hdead0000 ^ 32'(cyc);
    if (rd_s[k] && fq[k].size() > 0) begin
      w = fq[k].pop_front();
    end
    if (k == 0) begin
      fd[0] = w;
    end else begin
      fd[1]  = st0[1];
      st0[1] = w;
    end
    fifo_empty[k] = (fq[k].size() == 0);
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      if (rmode[k] == 1)
        m_ready[k] = 1'($urandom_range(0, 1));
      else
        m_ready[k] = rval[k];
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) sample(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) fifo_step(k);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      enable[k] = 1'b0;
      rmode[k]  = 0;
      rval[k]   = 1'b0;
    end
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic run_until(int k, int n, int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      cycle();
      if (popped[k] >= n && idle_s[k]) done = 1'b1;
    end
    chk("drain_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    vec_t          tbl [6];
    vec_t          v;
    int            k;
    int            ib;
    bit            seen;
    logic [DW-1:0] d1;

    tbl[0] = '{0, 4,  16, 0,  4, 16};
    tbl[1] = '{1, 7, 200, 1, 28,  0};
    tbl[2] = '{0, 0,  32, 0,  0, 32};
    tbl[3] = '{0, 1,  32, 0, 32, 32};
    tbl[4] = '{1, 1,  32, 0, 32, 32};
    tbl[5] = '{1, 5,  40, 1,  8,  0};

    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b0;
    pkt_len = '0;
    for (int j = 0; j < 2; j++) begin
      enable[j]  = 1'b0;
      m_ready[j] = 1'b0;
      rval[j]    = 1'b0;
      rmode[j]   = 0;
    end

    do_reset();
    for (int j = 0; j < 2; j++) begin
      chk("rst_rd_en",  64'(rd_en[j]),   64'(0));
      chk("rst_valid",  64'(m_valid[j]), 64'(0));
      chk("rst_data",   64'(m_data[j]),  64'(0));
      chk("rst_last",   64'(m_last[j]),  64'(0));
      chk("rst_idle",   64'(idle[j]),    64'(1));
    end

    for (int t = 0; t < 6; t++) begin
      v       = tbl[t];
      pkt_len = LW'(v.plen);
      do_reset();
      k        = v.sel;
      rmode[k] = v.rm;
      rval[k]  = 1'b1;
      preload(k, v.nw, t * 1000);
      enable[k] = 1'b1;
      run_until(k, v.nw, v.nw * 8 + 50);
      chk("tbl_beats",  64'(popped[k]), 64'(v.nw));
      chk("tbl_lasts",  64'(lasts[k]),  64'(v.lasts));
      chk("tbl_issued", 64'(issued[k]), 64'(v.nw));
      chk("tbl_left",   64'(exp_q[k].size()), 64'(0));
      if (v.run != 0) begin
        chk("tbl_rd_run", 64'(rd_run[k]), 64'(v.run));
        chk("tbl_span",
            64'(last_b[k] - first_b[k]), 64'(v.nw - 1));
      end
      enable[k] = 1'b0;
    end

    pkt_len = 16'd4;
    do_reset();
    rval[0] = 1'b1;
    preload(0, 20, 5000);
    enable[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (popped[0] >= 1) seen = 1'b1;
    end
    chk("bp_first_beat", 64'(seen), 64'(1));
    rval[0] = 1'b0;
    cycle();
    d1 = m_data[0];
    repeat (9) cycle();
    chk("bp_rd_off",  64'(rd_s[0]), 64'(0));
    chk("bp_valid",   64'(valid_s[0]), 64'(1));
    chk("bp_full",    64'(issued[0] - popped[0]), 64'(3));
    chk("bp_stable",  64'(m_data[0]), 64'(d1));
    rval[0] = 1'b1;
    run_until(0, 20, 200);
    chk("bp_beats", 64'(popped[0]), 64'(20));
    chk("bp_lasts", 64'(lasts[0]),  64'(5));
    chk("bp_left",  64'(exp_q[0].size()), 64'(0));

    pkt_len = 16'd2;
    do_reset();
    rval[0] = 1'b1;
    preload(0, 10, 6000);
    enable[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (popped[0] >= 1) seen = 1'b1;
    end
    chk("ar_first_beat", 64'(seen), 64'(1));
    rval[0] = 1'b0;
    repeat (6) cycle();
    chk("ar_buffered", 64'(issued[0] - popped[0]), 64'(3));
    chk("ar_pre_valid", 64'(m_valid[0]), 64'(1));
    rst = 1'b1;
    #1;
    chk("ar_rd_en", 64'(rd_en[0]),   64'(0));
    chk("ar_valid", 64'(m_valid[0]), 64'(0));
    chk("ar_idle",  64'(idle[0]),    64'(1));
    chk("ar_last",  64'(m_last[0]),  64'(0));
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    rval[0] = 1'b1;
    preload(0, 4, 7000);
    run_until(0, 4, 60);
    chk("ar_beats", 64'(popped[0]), 64'(4));
    chk("ar_lasts", 64'(lasts[0]),  64'(2));

    pkt_len = 16'd3;
    do_reset();
    rval[1] = 1'b1;
    preload(1, 5, 8000);
    enable[1] = 1'b1;
    run_until(1, 5, 60);
    chk("em_beats",  64'(popped[1]), 64'(5));
    chk("em_issued", 64'(issued[1]), 64'(5));
    chk("em_rd_off", 64'(rd_s[1]),   64'(0));
    chk("em_valid",  64'(valid_s[1]), 64'(0));
    chk("em_idle",   64'(idle_s[1]),  64'(1));
    preload(1, 10, 9000);
    ib = issued[1];
    repeat (2) cycle();
    chk("en_two_issued", 64'(issued[1] - ib), 64'(2));
    enable[1] = 1'b0;
    repeat (10) cycle();
    chk("en_no_more", 64'(issued[1] - ib), 64'(2));
    chk("en_beats",   64'(popped[1]), 64'(7));
    chk("en_idle",    64'(idle_s[1]), 64'(1));
    chk("en_fifo",    64'(fq[1].size()), 64'(8));
    enable[1] = 1'b1;
    run_until(1, 15, 100);
    chk("en_total", 64'(popped[1]), 64'(15));
    chk("en_lasts", 64'(lasts[1]),  64'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
